// File: rtl/sample_sched_if.sv
// Triangle-in / sample-out bundle for the sample scheduler.
// master drives triangles and stall, slave produces samples.
interface sample_sched_if #(
   parameter int SIGFIG = 24,
   parameter int VERTS  = 3,
   parameter int AXIS   = 3,
   parameter int COLORS = 3
);
   logic signed [SIGFIG-1:0] tri_R13S [VERTS][AXIS];
   logic        [SIGFIG-1:0] color_R13U [COLORS];
   logic signed [SIGFIG-1:0] box_R13S [2][2];
   logic        [SIGFIG-1:0] step_R13U;
   logic                     validTri_R13H;
   logic                     stall_R14H;
   logic                     halt_RnnnnH;
   logic signed [SIGFIG-1:0] tri_R14S [VERTS][AXIS];
   logic        [SIGFIG-1:0] color_R14U [COLORS];
   logic signed [SIGFIG-1:0] sample_R14S [2];
   logic                     validSamp_R14H;
   logic                     triDone_R14H;

   modport master (
      output tri_R13S, color_R13U, box_R13S, step_R13U,
      output validTri_R13H, stall_R14H,
      input  halt_RnnnnH, tri_R14S, color_R14U,
      input  sample_R14S, validSamp_R14H, triDone_R14H
   );

   modport slave (
      input  tri_R13S, color_R13U, box_R13S, step_R13U,
      input  validTri_R13H, stall_R14H,
      output halt_RnnnnH, tri_R14S, color_R14U,
      output sample_R14S, validSamp_R14H, triDone_R14H
   );
endinterface

// File: rtl/sample_sched.sv
// Walks a triangle's bounding box in raster order, one sample per
// accepted cycle, holding upstream until the last sample is taken.
module sample_sched #(
   parameter int SIGFIG = 24,
   parameter int RADIX  = 10,
   parameter int VERTS  = 3,
   parameter int AXIS   = 3,
   parameter int COLORS = 3
) (
   input logic           clk,
   input logic           rst,
   sample_sched_if.slave bus
);
   if (RADIX >= SIGFIG) begin : g_bad_radix
      $error("RADIX must leave integer bits in SIGFIG");
   end

   typedef enum logic {IDLE, TEST} state_e;
   typedef logic signed [SIGFIG-1:0] coord_t;
   typedef logic signed [SIGFIG:0]   wide_t;

   state_e            state_q;
   coord_t            tri_q [VERTS][AXIS];
   logic [SIGFIG-1:0] color_q [COLORS];
   coord_t            llx_q;
   coord_t            urx_q;
   coord_t            ury_q;
   coord_t            sx_q;
   coord_t            sy_q;
   logic [SIGFIG-1:0] step_q;
   logic              valid_q;
   logic              halt_q;
   logic              done_q;

   wide_t nx;
   wide_t ny;
   wide_t urx_w;
   wide_t ury_w;
   logic  box_ok;

   // One extra bit keeps the step sum from wrapping near the max coord
   assign nx    = {sx_q[SIGFIG-1], sx_q} + {1'b0, step_q};
   assign ny    = {sy_q[SIGFIG-1], sy_q} + {1'b0, step_q};
   assign urx_w = {urx_q[SIGFIG-1], urx_q};
   assign ury_w = {ury_q[SIGFIG-1], ury_q};

   assign box_ok = (bus.box_R13S[1][0] >= bus.box_R13S[0][0]) &&
                   (bus.box_R13S[1][1] >= bus.box_R13S[0][1]);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         tri_q   <= '{default: '0};
         color_q <= '{default: '0};
         llx_q   <= '0;
         urx_q   <= '0;
         ury_q   <= '0;
         sx_q    <= '0;
         sy_q    <= '0;
         step_q  <= '0;
         valid_q <= 1'b0;
         halt_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (bus.validTri_R13H) begin
                  if (box_ok) begin
                     tri_q   <= bus.tri_R13S;
                     color_q <= bus.color_R13U;
                     llx_q   <= bus.box_R13S[0][0];
                     urx_q   <= bus.box_R13S[1][0];
                     ury_q   <= bus.box_R13S[1][1];
                     step_q  <= bus.step_R13U;
                     sx_q    <= bus.box_R13S[0][0];
                     sy_q    <= bus.box_R13S[0][1];
                     valid_q <= 1'b1;
                     halt_q  <= 1'b1;
                     state_q <= TEST;
                  end else begin
                     done_q <= 1'b1;
                  end
               end
            end
            TEST: begin
               if (!bus.stall_R14H) begin
                  if (nx <= urx_w) begin
                     sx_q <= nx[SIGFIG-1:0];
                  end else if (ny <= ury_w) begin
                     sx_q <= llx_q;
                     sy_q <= ny[SIGFIG-1:0];
                  end else begin
                     valid_q <= 1'b0;
                     halt_q  <= 1'b0;
                     done_q  <= 1'b1;
                     state_q <= IDLE;
                  end
               end
            end
         endcase
      end
   end

   assign bus.tri_R14S       = tri_q;
   assign bus.color_R14U     = color_q;
   assign bus.sample_R14S[0] = sx_q;
   assign bus.sample_R14S[1] = sy_q;
   assign bus.validSamp_R14H = valid_q;
   assign bus.halt_RnnnnH    = halt_q;
   assign bus.triDone_R14H   = done_q;
endmodule

// File: tb/tb_sample_sched.sv
// Random and directed triangles against a box-walk reference list.
module tb_sample_sched;
   localparam int SF = 24;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   nchk = 0;
   int   nbad = 0;

   sample_sched_if #(.SIGFIG(SF), .VERTS(3), .AXIS(3), .COLORS(3)) bus ();

   sample_sched #(
      .SIGFIG(SF), .RADIX(10), .VERTS(3), .AXIS(3), .COLORS(3)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      nchk++;
      if (got !== exp) begin
         nbad++;
         $display("FAIL %s got=%0h want=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [SF-1:0] rnd24();
      logic [31:0] r;
      r = $urandom;
      return r[SF-1:0];
   endfunction

   task automatic scramble();
      for (int v = 0; v < 3; v++)
         for (int a = 0; a < 3; a++) bus.tri_R13S[v][a] = rnd24();
      for (int c = 0; c < 3; c++) bus.color_R13U[c] = rnd24();
      for (int i = 0; i < 2; i++)
         for (int j = 0; j < 2; j++) bus.box_R13S[i][j] = rnd24();
      bus.step_R13U = rnd24();
   endtask

   task automatic chk_latched(input string tag,
                              input logic [SF-1:0] et[3][3],
                              input logic [SF-1:0] ec[3]);
      for (int v = 0; v < 3; v++)
         for (int a = 0; a < 3; a++)
            chk({tag, "_tri"}, {40'h0, bus.tri_R14S[v][a]}, {40'h0, et[v][a]});
      for (int c = 0; c < 3; c++)
         chk({tag, "_col"}, {40'h0, bus.color_R14U[c]}, {40'h0, ec[c]});
   endtask

   // mode 0: no stall, 1: random stall, 2: stall 3 cycles on 2nd sample
   task automatic run_tri(input longint llx, input longint lly,
                          input longint urx, input longint ury,
                          input longint step, input int mode,
                          input int abort_at);
      logic [63:0]   q[$];
      logic [SF-1:0] et [3][3];
      logic [SF-1:0] ec [3];
      logic [47:0]   smp;
      int idx, held, cyc;
      bit st;
      for (longint y = lly; y <= ury; y += step)
         for (longint x = llx; x <= urx; x += step)
            q.push_back({16'h0, x[SF-1:0], y[SF-1:0]});

      @(negedge clk);
      for (int v = 0; v < 3; v++)
         for (int a = 0; a < 3; a++) begin
            et[v][a] = rnd24();
            bus.tri_R13S[v][a] = et[v][a];
         end
      for (int c = 0; c < 3; c++) begin
         ec[c] = rnd24();
         bus.color_R13U[c] = ec[c];
      end
      bus.box_R13S[0][0] = llx[SF-1:0];
      bus.box_R13S[0][1] = lly[SF-1:0];
      bus.box_R13S[1][0] = urx[SF-1:0];
      bus.box_R13S[1][1] = ury[SF-1:0];
      bus.step_R13U      = step[SF-1:0];
      bus.validTri_R13H  = 1'b1;
      bus.stall_R14H     = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
      bus.validTri_R13H = 1'b0;
      bus.stall_R14H    = 1'b0;

      if (q.size() == 0) begin
         chk("inv_valid", {63'h0, bus.validSamp_R14H}, 64'h0);
         chk("inv_halt", {63'h0, bus.halt_RnnnnH}, 64'h0);
         chk("inv_done", {63'h0, bus.triDone_R14H}, 64'h1);
         @(posedge clk);
         #1;
         chk("inv_done_clr", {63'h0, bus.triDone_R14H}, 64'h0);
         chk("inv_halt2", {63'h0, bus.halt_RnnnnH}, 64'h0);
         chk("inv_valid2", {63'h0, bus.validSamp_R14H}, 64'h0);
         return;
      end

      chk_latched("acc", et, ec);
      idx  = 0;
      held = 0;
      cyc  = 0;
      while (idx < q.size() && cyc < 4000) begin
         smp = {bus.sample_R14S[0], bus.sample_R14S[1]};
         chk("valid", {63'h0, bus.validSamp_R14H}, 64'h1);
         chk("halt", {63'h0, bus.halt_RnnnnH}, 64'h1);
         chk("done_early", {63'h0, bus.triDone_R14H}, 64'h0);
         chk("sample", {16'h0, smp}, q[idx]);
         if (idx == abort_at) begin
            rst = 1'b0;
            #1;
            chk("rst_valid", {63'h0, bus.validSamp_R14H}, 64'h0);
            chk("rst_halt", {63'h0, bus.halt_RnnnnH}, 64'h0);
            chk("rst_done", {63'h0, bus.triDone_R14H}, 64'h0);
            smp = {bus.sample_R14S[0], bus.sample_R14S[1]};
            chk("rst_sample", {16'h0, smp}, 64'h0);
            @(negedge clk);
            rst = 1'b1;
            bus.stall_R14H    = 1'b0;
            bus.validTri_R13H = 1'b0;
            @(posedge clk);
            #1;
            chk("rst_nodone", {63'h0, bus.triDone_R14H}, 64'h0);
            chk("rst_idle", {63'h0, bus.validSamp_R14H}, 64'h0);
            return;
         end
         case (mode)
            1:       st = ($urandom_range(0, 3) == 0);
            2:       st = (idx == 1 && held < 3);
            default: st = 1'b0;
         endcase
         if (st) held++;
         bus.stall_R14H = st;
         scramble();
         if (!st && idx == q.size() - 1) bus.validTri_R13H = 1'b0;
         else bus.validTri_R13H = 1'($urandom_range(0, 1));
         @(posedge clk);
         #1;
         if (!st) idx++;
         cyc++;
      end
      chk("all_samples", 64'(idx), 64'(q.size()));
      bus.stall_R14H    = 1'b0;
      bus.validTri_R13H = 1'b0;
      chk("end_valid", {63'h0, bus.validSamp_R14H}, 64'h0);
      chk("end_halt", {63'h0, bus.halt_RnnnnH}, 64'h0);
      chk("end_done", {63'h0, bus.triDone_R14H}, 64'h1);
      chk_latched("end", et, ec);
      @(posedge clk);
      #1;
      chk("done_pulse", {63'h0, bus.triDone_R14H}, 64'h0);
      chk("idle_valid", {63'h0, bus.validSamp_R14H}, 64'h0);
   endtask

   initial begin
      longint step, llx, lly, urx, ury;
      logic [47:0] smp;
      bus.validTri_R13H = 1'b0;
      bus.stall_R14H    = 1'b0;
      scramble();
      repeat (2) @(posedge clk);
      #1;
      smp = {bus.sample_R14S[0], bus.sample_R14S[1]};
      chk("reset_valid", {63'h0, bus.validSamp_R14H}, 64'h0);
      chk("reset_halt", {63'h0, bus.halt_RnnnnH}, 64'h0);
      chk("reset_done", {63'h0, bus.triDone_R14H}, 64'h0);
      chk("reset_sample", {16'h0, smp}, 64'h0);
      chk("reset_tri", {40'h0, bus.tri_R14S[0][0]}, 64'h0);
      @(negedge clk);
      rst = 1'b1;

      run_tri(0, 0, 1024, 1024, 512, 0, -1);
      run_tri(0, 0, 1024, 1024, 512, 2, -1);
      run_tri(2048, 0, 1024, 0, 512, 0, -1);
      run_tri(-512, -512, -512, -512, 256, 0, -1);
      run_tri(0, 0, 1024, 1024, 512, 0, 4);
      run_tri(0, 0, 1024, 1024, 512, 1, -1);
      run_tri(8388607 - 2048, 0, 8388607, 1024, 1024, 1, -1);
      run_tri(-4096, 8388607 - 1024, -3072, 8388607, 512, 0, -1);

      for (int t = 0; t < 40; t++) begin
         step = 64 << $urandom_range(0, 4);
         llx  = (longint'($urandom_range(0, 16)) - 8) * step;
         lly  = (longint'($urandom_range(0, 16)) - 8) * step;
         urx  = llx + longint'($urandom_range(0, 3)) * step;
         ury  = lly + longint'($urandom_range(0, 3)) * step;
         if ($urandom_range(0, 5) == 0) urx = llx - step;
         if ($urandom_range(0, 7) == 0) ury = lly - step;
         run_tri(llx, lly, urx, ury, step, 1,
                 ($urandom_range(0, 9) == 0) ? 1 : -1);
      end

      $display("test done: total=%0d bad=%0d", nchk, nbad);
      $finish;
   end
endmodule

// File: doc/sample_sched.md
SAMPLE_SCHED -- requirements
Module: sample_sched

Interface
REQ-001 SHALL have parameter SIGFIG, default 24, meaning bits in position and color.
REQ-002 SHALL have parameter RADIX, default 10, meaning fraction bits of position.
REQ-003 SHALL have parameter VERTS, default 3, meaning vertices per triangle.
REQ-004 SHALL have parameter AXIS, default 3, meaning axes per vertex (x,y,z).
REQ-005 SHALL have parameter COLORS, default 3, meaning color channels.
REQ-006 SHALL have port clk  input  1  meaning the single clock; all state on rising edge.
REQ-007 SHALL have port rst  input  1  meaning reset, asynchronous, active-low.
REQ-008 SHALL have port tri_R13S  input  signed SIGFIG x [VERTS][AXIS]  meaning triangle vertices.
REQ-009 SHALL have port color_R13U  input  SIGFIG x [COLORS]  meaning triangle color.
REQ-010 SHALL have port box_R13S  input  signed SIGFIG x [2][2]  meaning bounding box, [0]=lower-left (x,y), [1]=upper-right (x,y), sample-grid aligned.
REQ-011 SHALL have port step_R13U  input  SIGFIG  meaning sample pitch, nonzero power of two.
REQ-012 SHALL have port validTri_R13H  input  1  meaning triangle and box valid.
REQ-013 SHALL have port stall_R14H  input  1  meaning downstream sample test cannot accept this cycle.
REQ-014 SHALL have port halt_RnnnnH  output  1  meaning upstream must hold its triangle.
REQ-015 SHALL have port tri_R14S / color_R14U  output  same shapes as inputs  meaning latched triangle and color.
REQ-016 SHALL have port sample_R14S  output  signed SIGFIG x [2]  meaning current sample (x,y).
REQ-017 SHALL have port validSamp_R14H  output  1  meaning sample_R14S is valid.
REQ-018 SHALL have port triDone_R14H  output  1  meaning one-cycle pulse when a triangle's last sample is consumed.

Function
REQ-019 SHALL implement two states, IDLE and TEST; all outputs registered.
REQ-020 SHALL in IDLE drive halt_RnnnnH=0 and validSamp_R14H=0.
REQ-021 SHALL in IDLE, on validTri_R13H=1 with box[1].x>=box[0].x and box[1].y>=box[0].y (signed), latch tri, color, box, step, set sample_R14S=box[0], validSamp_R14H=1, halt_RnnnnH=1, enter TEST next cycle (latency 1).
REQ-022 SHALL in IDLE discard a valid triangle with an inverted box: no sample issued, triDone_R14H pulses once, remain IDLE.
REQ-023 SHALL accept a triangle in IDLE regardless of stall_R14H.
REQ-024 SHALL in TEST with stall_R14H=1 hold every output and all internal state unchanged.
REQ-025 SHALL in TEST with stall_R14H=0 advance in raster order: if x+step<=ur.x then x+=step; else if y+step<=ur.y then x=ll.x, y+=step; else last sample consumed.
REQ-026 SHALL on last-sample consumption clear validSamp_R14H and halt_RnnnnH, pulse triDone_R14H for one cycle, return to IDLE; next triangle accepted no earlier than the following cycle.
REQ-027 SHALL compute x+step and y+step in SIGFIG+1 signed bits so no wrap-around occurs near the positive limit.
REQ-028 SHALL ignore tri/color/box/step/validTri inputs while in TEST.

Reset
REQ-029 SHALL on rst=0 immediately force IDLE, validSamp_R14H=0, halt_RnnnnH=0, triDone_R14H=0, all data outputs 0.
REQ-030 SHALL on reset mid-triangle abort it with no further samples and no triDone pulse.

Verification
REQ-031 SHALL cover: RADIX=10, box (0,0)-(1024,1024), step=512, no stall -> 9 samples x,y in {0,512,1024}, row-major, consecutive cycles, triDone one cycle after ninth.
REQ-032 SHALL cover: same box, stall_R14H=1 for 3 cycles at sample (512,0) -> (512,0) held 4 cycles, sequence unchanged.
REQ-033 SHALL cover: box (2048,0)-(1024,0) -> zero samples, triDone pulse, halt stays 0.
REQ-034 SHALL cover: single-point box (-512,-512)-(-512,-512), step=256 -> exactly one sample (-512,-512).
REQ-035 SHALL cover: rst=0 asserted after 4th sample -> validSamp and halt 0 asynchronously, no triDone, next triangle starts at its lower-left.
REQ-036 SHALL cover: box ur.x=2^(SIGFIG-1)-1 aligned, step=1024 -> iteration terminates, no wrap to negative x.
